// File: rtl/pkg_1553.sv
// Shared types and helpers for the 1553 receive path.
package pkg_1553;

  typedef enum logic [1:0] {StIdle, StData, StDone} state_e;

  localparam int unsigned WORD_BITS = 16;
  localparam int unsigned PAR_BITS  = 1;

  // Samples in one half of the 3-bit-time sync pattern.
  function automatic int unsigned sync_half(input int unsigned osr);
    return (3 * osr) / 2;
  endfunction

  // High when the 17-bit frame (data + parity) fails odd parity.
  function automatic logic odd_parity_err(input logic [WORD_BITS+PAR_BITS-1:0] frame);
    return ~^frame;
  endfunction

endpackage

// File: rtl/sync_detect_1553.sv
// Input synchronizers, level/valid sample histories and the sync-pattern matcher.
module sync_detect_1553
  import pkg_1553::*;
#(
  parameter int unsigned OSR      = 8,
  parameter int unsigned EDGE_TOL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_p_i,
  input  logic rx_n_i,
  output logic lvl_o,
  output logic vld_o,
  output logic match_o,
  output logic sync_csw_o
);

  localparam int unsigned M  = sync_half(OSR);
  localparam int unsigned HW = 2 * M;

  logic p_q1, p_q2, n_q1, n_q2;
  logic [HW-1:0] h_q, v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q1 <= 1'b0;
      p_q2 <= 1'b0;
      n_q1 <= 1'b0;
      n_q2 <= 1'b0;
      h_q  <= '0;
      v_q  <= '0;
    end else begin
      p_q1 <= rx_p_i;
      p_q2 <= p_q1;
      n_q1 <= rx_n_i;
      n_q2 <= n_q1;
      h_q  <= {h_q[HW-2:0], p_q2};
      v_q  <= {v_q[HW-2:0], p_q2 ^ n_q2};
    end
  end

  logic first_ok, second_ok, v_ok;

  // Index 0 is the newest sample; the mid-sync edge sits between M and M-1.
  always_comb begin
    first_ok  = 1'b1;
    second_ok = 1'b1;
    v_ok      = 1'b1;
    for (int unsigned i = M + 1; i <= HW - 1 - EDGE_TOL; i++) begin
      if (h_q[i] != h_q[M]) first_ok = 1'b0;
    end
    for (int unsigned i = EDGE_TOL; i <= M - 2; i++) begin
      if (h_q[i] == h_q[M]) second_ok = 1'b0;
    end
    for (int unsigned i = EDGE_TOL; i <= HW - 1 - EDGE_TOL; i++) begin
      if (!v_q[i]) v_ok = 1'b0;
    end
    match_o = (h_q[M-1] != h_q[M]) && first_ok && second_ok && v_ok;
  end

  assign sync_csw_o = h_q[M];
  assign lvl_o      = h_q[0];
  assign vld_o      = v_q[0];

  // Edge-tolerance samples are deliberately never inspected.
  logic unused_hist_bits;
  assign unused_hist_bits = ^{h_q, v_q};

endmodule

// File: rtl/rx_word_1553.sv
// MIL-STD-1553 Manchester II word receiver: sync detect, bit decode, parity check.
module rx_word_1553
  import pkg_1553::*;
#(
  parameter int unsigned OSR      = 8,
  parameter int unsigned EDGE_TOL = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_en,
  input  logic        rx_p,
  input  logic        rx_n,
  output logic [15:0] rx_dword,
  output logic        rx_csw,
  output logic        rx_dw,
  output logic        rx_perr,
  output logic        rx_dval,
  output logic        rx_merr,
  output logic        rx_busy
);

  localparam int unsigned FrameBits = WORD_BITS + PAR_BITS;
  localparam int unsigned PhW       = $clog2(OSR);
  localparam logic [PhW-1:0] PhA    = PhW'(OSR / 4);
  localparam logic [PhW-1:0] PhB    = PhW'(3 * OSR / 4);
  localparam logic [PhW-1:0] PhLast = PhW'(OSR - 1);
  localparam logic [4:0] LastBit    = 5'(FrameBits - 1);

  logic lvl, vld, match, sync_csw;

  sync_detect_1553 #(
    .OSR      (OSR),
    .EDGE_TOL (EDGE_TOL)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_p_i     (rx_p),
    .rx_n_i     (rx_n),
    .lvl_o      (lvl),
    .vld_o      (vld),
    .match_o    (match),
    .sync_csw_o (sync_csw)
  );

  state_e                 state_q;
  logic [PhW-1:0]         phase_q;
  logic [4:0]             bit_q;
  logic                   a_q;
  logic                   l_q;
  logic [FrameBits-1:0]   shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      bit_q    <= '0;
      a_q      <= 1'b0;
      l_q      <= 1'b0;
      shift_q  <= '0;
      rx_dword <= '0;
      rx_csw   <= 1'b0;
      rx_dw    <= 1'b0;
      rx_perr  <= 1'b0;
      rx_dval  <= 1'b0;
      rx_merr  <= 1'b0;
      rx_busy  <= 1'b0;
    end else begin
      rx_dval <= 1'b0;
      rx_merr <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_en && match) begin
            l_q     <= sync_csw;
            phase_q <= '0;
            bit_q   <= '0;
            rx_busy <= 1'b1;
            state_q <= StData;
          end
        end
        StData: begin
          phase_q <= phase_q + 1'b1;
          if (!rx_en) begin
            rx_busy <= 1'b0;
            state_q <= StIdle;
          end else if (!vld) begin
            rx_merr <= 1'b1;
            rx_busy <= 1'b0;
            state_q <= StIdle;
          end else if (phase_q == PhB && a_q == lvl) begin
            // No mid-bit transition: not a Manchester bit.
            rx_merr <= 1'b1;
            rx_busy <= 1'b0;
            state_q <= StIdle;
          end else begin
            if (phase_q == PhA) a_q <= lvl;
            if (phase_q == PhB) shift_q <= {shift_q[FrameBits-2:0], a_q};
            if (phase_q == PhLast) begin
              phase_q <= '0;
              if (bit_q == LastBit) begin
                rx_busy <= 1'b0;
                state_q <= StDone;
              end else begin
                bit_q <= bit_q + 5'd1;
              end
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          if (rx_en) begin
            rx_dword <= shift_q[FrameBits-1:1];
            rx_perr  <= odd_parity_err(shift_q);
            rx_csw   <= l_q;
            rx_dw    <= ~l_q;
            rx_dval  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
